// File: rtl/vga_scanout.sv
// VGA 640x480@60 timing generator and 2x2-upscaling reader for a 320x240 RGB444 frame buffer.
// Define SCAN_DBUF_EN to add a bank bit on fb_addr and a frame-boundary swap handshake.
module vga_scanout #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef SCAN_DBUF_EN
  output logic [ADDR_W:0]   fb_addr,
  input  logic              swap_req,
  output logic              swap_ack,
`else
  output logic [ADDR_W-1:0] fb_addr,
`endif
  output logic              fb_rd,
  input  logic [11:0]       fb_data,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vga_de,
  output logic              frame_start
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);
  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = $clog2(IMG_H);

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_VIS_C = HW'(H_VIS);
  localparam logic [HW-1:0] HS_BEG  = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] HS_END  = HW'(H_VIS + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_VIS_C = VW'(V_VIS);
  localparam logic [VW-1:0] VS_BEG  = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] VS_END  = VW'(V_VIS + V_FP + V_SYNC);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_last;
  logic          v_last;
  logic          visible;
  logic          hs_act;
  logic          vs_act;
  logic          first_pix;

  logic vld_p1, hs_p1, vs_p1, fs_p1;
  logic vld_p2, hs_p2, vs_p2, fs_p2;

  // Row-major address; the 320-wide case reduces to two shifts and an add.
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [RW-1:0] row,
                                                 input logic [CW-1:0] col);
    logic [ADDR_W-1:0] r;
    logic [ADDR_W-1:0] c;
    r = ADDR_W'(row);
    c = ADDR_W'(col);
    if (IMG_W == 320) pix_addr = (r << 8) + (r << 6) + c;
    else              pix_addr = (r * ADDR_W'(IMG_W)) + c;
  endfunction

  assign h_last    = (h_cnt == H_LAST);
  assign v_last    = (v_cnt == V_LAST);
  assign visible   = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
  assign hs_act    = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign vs_act    = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
  assign first_pix = (h_cnt == '0) && (v_cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

`ifdef SCAN_DBUF_EN
  logic bank;
  logic frame_last;

  assign frame_last = h_last && v_last;

  // The bank flips on the last clock of a frame so the next frame reads one bank throughout.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank     <= 1'b0;
      swap_ack <= 1'b0;
    end else begin
      swap_ack <= frame_last && swap_req;
      if (frame_last && swap_req) bank <= ~bank;
    end
  end
`endif

  // Stage 1: frame-buffer request, address held through blanking
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fb_addr <= '0;
      vld_p1  <= 1'b0;
      hs_p1   <= 1'b0;
      vs_p1   <= 1'b0;
      fs_p1   <= 1'b0;
    end else begin
      vld_p1 <= visible;
      hs_p1  <= hs_act;
      vs_p1  <= vs_act;
      fs_p1  <= first_pix;
      if (visible) begin
`ifdef SCAN_DBUF_EN
        fb_addr <= {bank, pix_addr(v_cnt[RW:1], h_cnt[CW:1])};
`else
        fb_addr <= pix_addr(v_cnt[RW:1], h_cnt[CW:1]);
`endif
      end
    end
  end

  assign fb_rd = vld_p1;

  // Stage 2: RAM read in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p2 <= 1'b0;
      hs_p2  <= 1'b0;
      vs_p2  <= 1'b0;
      fs_p2  <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      hs_p2  <= hs_p1;
      vs_p2  <= vs_p1;
      fs_p2  <= fs_p1;
    end
  end

  // Stage 3: output registers, colour forced black outside the visible area
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vga_r       <= 4'h0;
      vga_g       <= 4'h0;
      vga_b       <= 4'h0;
      vga_de      <= 1'b0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      vga_r       <= vld_p2 ? fb_data[11:8] : 4'h0;
      vga_g       <= vld_p2 ? fb_data[7:4]  : 4'h0;
      vga_b       <= vld_p2 ? fb_data[3:0]  : 4'h0;
      vga_de      <= vld_p2;
      vga_hs      <= ~hs_p2;
      vga_vs      <= ~vs_p2;
      frame_start <= fs_p2;
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: full-size instance for addressing, reduced-timing instance for whole frames.
// Both are checked every clock against a position-based model; SCAN_DBUF_EN adds a swap sequence.
`timescale 1ns/1ps
module tb_vga_scanout;
  localparam int AW = 17;
`ifdef SCAN_DBUF_EN
  localparam int FBW = AW + 1;
`else
  localparam int FBW = AW;
`endif

  typedef struct {
    int hv; int hfp; int hsw; int hbp;
    int vv; int vfp; int vsw; int vbp;
    int iw;
  } tim_t;
  typedef struct packed {
    logic de; logic hs; logic vs; logic fs; logic rd;
    logic [11:0] rgb;
    logic [AW-1:0] addr;
  } out_t;
  typedef struct {
    int   k;
    out_t o;
  } vec_t;

  tim_t td = '{640, 16, 96, 48, 480, 10, 2, 33, 320};
  tim_t ts = '{64, 4, 8, 4, 16, 2, 2, 2, 32};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic swap_req;
  int   mode;
  int   k = 0;
  bit   mon_en;
  int   checks = 0;
  int   errors = 0;
  logic [11:0] mem [0:76799];

  logic [FBW-1:0] fb_addr_d, fb_addr_s;
  logic           fb_rd_d, fb_rd_s;
  logic [11:0]    data_d, data_s;
  logic [3:0]     r_d, g_d, b_d, r_s, g_s, b_s;
  logic           hs_d, vs_d, de_d, fs_d, hs_s, vs_s, de_s, fs_s;
  logic           ack_d, ack_s;
  out_t           act_d, act_s;

  vga_scanout dut (
    .clk(clk), .rst_n(rst_n),
`ifdef SCAN_DBUF_EN
    .swap_req(1'b0), .swap_ack(ack_d),
`endif
    .fb_addr(fb_addr_d), .fb_rd(fb_rd_d), .fb_data(data_d),
    .vga_r(r_d), .vga_g(g_d), .vga_b(b_d),
    .vga_hs(hs_d), .vga_vs(vs_d), .vga_de(de_d), .frame_start(fs_d)
  );

  vga_scanout #(
    .H_VIS(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_VIS(16), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .IMG_W(32), .IMG_H(8), .ADDR_W(AW)
  ) dut_s (
    .clk(clk), .rst_n(rst_n),
`ifdef SCAN_DBUF_EN
    .swap_req(swap_req), .swap_ack(ack_s),
`endif
    .fb_addr(fb_addr_s), .fb_rd(fb_rd_s), .fb_data(data_s),
    .vga_r(r_s), .vga_g(g_s), .vga_b(b_s),
    .vga_hs(hs_s), .vga_vs(vs_s), .vga_de(de_s), .frame_start(fs_s)
  );

`ifndef SCAN_DBUF_EN
  assign ack_d = 1'b0;
  assign ack_s = 1'b0;
`endif

  assign act_d = '{de_d, hs_d, vs_d, fs_d, fb_rd_d, {r_d, g_d, b_d}, fb_addr_d[AW-1:0]};
  assign act_s = '{de_s, hs_s, vs_s, fs_s, fb_rd_s, {r_s, g_s, b_s}, fb_addr_s[AW-1:0]};

  function automatic logic [11:0] dat(input int a);
    if (a < 0 || a > 76799) return 12'h000;
    case (mode)
      0:       return 12'(a);
      1:       return 12'hFFF;
      default: return mem[a];
    endcase
  endfunction

  function automatic int pa(input tim_t t, input int h, input int v);
    return (v / 2) * t.iw + h / 2;
  endfunction

  // Outputs after k clock edges since the last reset edge, from screen position alone.
  function automatic out_t model(input tim_t t, input int kk);
    out_t o;
    int ht, vt, p, h, v;
    ht = t.hv + t.hfp + t.hsw + t.hbp;
    vt = t.vv + t.vfp + t.vsw + t.vbp;
    o = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000, '0};
    if (kk >= 3) begin
      p = kk - 3; h = p % ht; v = (p / ht) % vt;
      o.de  = (h < t.hv) && (v < t.vv);
      o.hs  = !((h >= t.hv + t.hfp) && (h < t.hv + t.hfp + t.hsw));
      o.vs  = !((v >= t.vv + t.vfp) && (v < t.vv + t.vfp + t.vsw));
      o.fs  = (h == 0) && (v == 0);
      o.rgb = o.de ? dat(pa(t, h, v)) : 12'h000;
    end
    if (kk >= 1) begin
      p = kk - 1; h = p % ht; v = (p / ht) % vt;
      o.rd = (h < t.hv) && (v < t.vv);
      if (o.rd)          o.addr = AW'(pa(t, h, v));
      else if (v < t.vv) o.addr = AW'(pa(t, t.hv - 1, v));
      else               o.addr = AW'(pa(t, t.hv - 1, t.vv - 1));
    end
    return o;
  endfunction

  task automatic cmp(input string nm, input out_t a, input out_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s k=%0d got de=%b hs=%b vs=%b fs=%b rd=%b rgb=%h addr=%0d expected de=%b hs=%b vs=%b fs=%b rd=%b rgb=%h addr=%0d",
               nm, k, a.de, a.hs, a.vs, a.fs, a.rd, a.rgb, a.addr,
               e.de, e.hs, e.vs, e.fs, e.rd, e.rgb, e.addr);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s k=%0d got %0h expected %0h", nm, k, a, e);
    end
  endtask

  task automatic wait_k(input int n);
    while (k < n) @(negedge clk);
  endtask

  task automatic reset_pulse(input int cycles, input int new_mode);
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (cycles - 1) @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    mode = new_mode;
  endtask

  always @(posedge clk) k <= rst_n ? k + 1 : 0;

  always @(posedge clk) begin
    data_d <= dat(int'(fb_addr_d[AW-1:0]));
    data_s <= dat(int'(fb_addr_s[AW-1:0]));
  end

  always @(negedge clk) begin
    if (mon_en) begin
      cmp("model_full", act_d, model(td, k));
      cmp("model_small", act_s, model(ts, k));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout k=%0d", k);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs [13];
    int   early;
    vecs[0]  = '{1,    '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 12'h000, 17'd0}};
    vecs[1]  = '{2,    '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 12'h000, 17'd0}};
    vecs[2]  = '{3,    '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 12'h000, 17'd1}};
    vecs[3]  = '{4,    '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 12'h000, 17'd1}};
    vecs[4]  = '{5,    '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 12'h001, 17'd2}};
    vecs[5]  = '{642,  '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h13F, 17'd319}};
    vecs[6]  = '{643,  '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 17'd319}};
    vecs[7]  = '{659,  '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 17'd319}};
    vecs[8]  = '{754,  '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 17'd319}};
    vecs[9]  = '{755,  '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 17'd319}};
    vecs[10] = '{803,  '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 12'h000, 17'd1}};
    vecs[11] = '{1603, '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 12'h140, 17'd321}};
    vecs[12] = '{1605, '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 12'h141, 17'd322}};

    rst_n = 1'b0; swap_req = 1'b0; mode = 0; mon_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 mon_en = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      wait_k(vecs[i].k);
      cmp($sformatf("vec%0d", i), act_d, vecs[i].o);
    end
    wait_k(3600);

    for (int i = 0; i < 76800; i++) mem[i] = 12'($urandom);
    mem[0] = 12'hA5C;
    wait_k(1900);
    reset_pulse(1, 2);
    wait_k(2);
    chk("midrst_de_k2", {31'd0, de_d}, 32'd0);
    chk("midrst_rgb_k2", {20'd0, r_d, g_d, b_d}, 32'd0);
    wait_k(3);
    chk("midrst_de_k3", {31'd0, de_d}, 32'd1);
    chk("midrst_fs_k3", {31'd0, fs_d}, 32'd1);
    chk("midrst_rgb_k3", {20'd0, r_d, g_d, b_d}, 32'hA5C);
    wait_k(1000);

    reset_pulse(2, 1);
    wait_k(2000);

    for (int it = 0; it < 6; it++) begin
      reset_pulse(int'($urandom_range(1, 3)), 2);
      wait_k(int'($urandom_range(50, 3600)));
    end

`ifdef SCAN_DBUF_EN
    reset_pulse(1, 0);
    wait_k(500);
    @(posedge clk); #1 swap_req = 1'b1;
    early = 0;
    while (k < 1760) begin
      @(negedge clk);
      if (k < 1760 && ack_s !== 1'b0) early++;
      if (ack_d !== 1'b0) early++;
    end
    chk("swap_early", early, 0);
    chk("swap_ack1", {31'd0, ack_s}, 32'd1);
    wait_k(1761);
    chk("swap_ack1_len", {31'd0, ack_s}, 32'd0);
    chk("swap_bank1", {31'd0, fb_addr_s[AW]}, 32'd1);
    wait_k(3520);
    chk("swap_ack2", {31'd0, ack_s}, 32'd1);
    wait_k(3521);
    chk("swap_bank2", {31'd0, fb_addr_s[AW]}, 32'd0);
    swap_req = 1'b0;
`else
    early = 0;
    chk("no_swap", early, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
